// File: rtl/acc_sequencer.sv
// acc_sequencer: multicycle fetch/decode/execute controller for the accumulator datapath.
// Define SEQ_TIMEOUT_EN to enable the ack-wait timeout and the sticky timeout_err flag.
module acc_sequencer #(
  parameter int unsigned DW      = 8,
  parameter int unsigned AW      = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  input  logic [DW-1:0] acc_val,
  output logic          acu_ce,
  output logic [1:0]    acu_src,
  output logic [2:0]    alu_op,
  output logic [DW-1:0] imm,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          illegal,
  output logic          timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_OPERAND,
    S_STORE,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_ST  = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  if ((AW > DW - 4) || (TIMEOUT == 0)) begin : g_bad_params
    $error("acc_sequencer: AW must not exceed DW-4 and TIMEOUT must be non-zero");
  end

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [3:0]    opcode;
  logic [AW-1:0] operand;
  logic          req_state;
  logic          timeout_hit;

  assign opcode    = ir_q[DW-1:DW-4];
  assign operand   = ir_q[AW-1:0];
  assign req_state = (state_q == S_FETCH) || (state_q == S_OPERAND) || (state_q == S_STORE);

  assign imm    = {{(DW-AW){1'b0}}, operand};
  assign pc     = pc_q;
  assign busy   = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted = (state_q == S_HALT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    acu_ce    = 1'b0;
    acu_src   = 2'd0;
    alu_op    = 3'd0;
    illegal   = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + {{(AW-1){1'b0}}, 1'b1};
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_FETCH;
        case (opcode)
          OP_NOP: ;
          OP_LDI: begin
            acu_ce  = 1'b1;
            acu_src = 2'd2;
          end
          OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_d = S_OPERAND;
          OP_ST:  state_d = S_STORE;
          OP_JMP: pc_d = operand;
          OP_JZ:  if (acc_val == '0) pc_d = operand;
          OP_HLT: state_d = S_HALT;
          default: illegal = 1'b1;
        endcase
      end
      S_OPERAND: begin
        mem_req  = 1'b1;
        mem_addr = operand;
        if (mem_ack) begin
          acu_ce = 1'b1;
          if (opcode == OP_LD) acu_src = 2'd1;
          else                 alu_op  = 3'(opcode - OP_ADD);
          state_d = S_FETCH;
        end
      end
      S_STORE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = operand;
        mem_wdata = acc_val;
        if (mem_ack) state_d = S_FETCH;
      end
      S_HALT: if (start) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
    // An ack in the limit cycle takes the normal path above.
    if (req_state && !mem_ack && timeout_hit) state_d = S_HALT;
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_q;
  logic          terr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_q <= '0;
      terr_q <= 1'b0;
    end else begin
      if (!req_state || mem_ack) wait_q <= '0;
      else                       wait_q <= wait_q + 1'b1;
      if (req_state && !mem_ack && timeout_hit) terr_q <= 1'b1;
    end
  end

  assign timeout_hit = (wait_q == CW'(TIMEOUT - 1));
  assign timeout_err = terr_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_acc_sequencer.sv
// Self-checking bench for acc_sequencer: instruction-level reference model expands each
// instruction into its expected per-cycle outputs, with randomized programs and ack delays.
module tb_acc_sequencer;

  logic       clk = 1'b0;
  logic       rstn, start, mem_ack;
  logic       mem_req, mem_we, acu_ce, busy, halted, illegal, timeout_err;
  logic [3:0] mem_addr, pc;
  logic [7:0] mem_wdata, mem_rdata, acc, alu_res, imm;
  logic [1:0] acu_src;
  logic [2:0] alu_op;

  acc_sequencer #(.DW(8), .AW(4), .TIMEOUT(15)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .acc_val(acc),
    .acu_ce(acu_ce), .acu_src(acu_src), .alu_op(alu_op), .imm(imm), .pc(pc),
    .busy(busy), .halted(halted), .illegal(illegal), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Environment: memory and accumulator datapath driven by the DUT controls.
  logic [7:0] tbmem [16];
  always_comb mem_rdata = tbmem[mem_addr];

  always_comb begin
    case (alu_op)
      3'd0: alu_res = acc + mem_rdata;
      3'd1: alu_res = acc - mem_rdata;
      3'd2: alu_res = acc & mem_rdata;
      3'd3: alu_res = acc | mem_rdata;
      3'd4: alu_res = acc ^ mem_rdata;
      default: alu_res = acc;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) acc <= '0;
    else if (acu_ce) begin
      case (acu_src)
        2'd0: acc <= alu_res;
        2'd1: acc <= mem_rdata;
        default: acc <= imm;
      endcase
    end
  end

  typedef struct packed {
    logic req, we, ack, start, ce, ill, busy, halted, terr;
    logic [3:0] addr;
    logic [7:0] wdata, imm;
    logic [1:0] src;
    logic [2:0] op;
    logic [3:0] pc;
  } rec_t;

  // Reference machine state.
  logic [7:0] m_mem [16];
  logic [7:0] m_acc, m_ir;
  logic [3:0] m_pc;
  logic       m_halted, m_terr;

  int vectors = 0, miscompares = 0;
  int ce_cnt, ill_cnt, busy_cnt, req_cnt;
  int force_d = -1;
  bit zero_wait = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic rec_t base();
    rec_t x;
    x       = '0;
    x.busy  = 1'b1;
    x.pc    = m_pc;
    x.imm   = {4'h0, m_ir[3:0]};
    x.terr  = m_terr;
    x.start = 1'($urandom_range(0, 1));
    x.ack   = ($urandom_range(0, 3) == 0);
    return x;
  endfunction

  // Called at posedge+1: drive inputs, compare at negedge, apply memory write at posedge.
  task automatic cycle(input rec_t e);
    logic       wr;
    logic [3:0] wa;
    logic [7:0] wd;
    mem_ack = e.ack;
    start   = e.start;
    @(negedge clk);
    chk("mem_req", 32'(mem_req), 32'(e.req));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("halted", 32'(halted), 32'(e.halted));
    chk("illegal", 32'(illegal), 32'(e.ill));
    chk("acu_ce", 32'(acu_ce), 32'(e.ce));
    chk("pc", 32'(pc), 32'(e.pc));
    chk("imm", 32'(imm), 32'(e.imm));
    chk("timeout_err", 32'(timeout_err), 32'(e.terr));
    if (e.req) begin
      chk("mem_we", 32'(mem_we), 32'(e.we));
      chk("mem_addr", 32'(mem_addr), 32'(e.addr));
      if (e.we) chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
    end
    if (e.ce) begin
      chk("acu_src", 32'(acu_src), 32'(e.src));
      if (e.src == 2'd0) chk("alu_op", 32'(alu_op), 32'(e.op));
    end
    wr = mem_req && mem_we && mem_ack;
    wa = mem_addr;
    wd = mem_wdata;
    if (acu_ce)  ce_cnt++;
    if (illegal) ill_cnt++;
    if (busy)    busy_cnt++;
    if (mem_req) req_cnt++;
    @(posedge clk);
    if (wr) tbmem[wa] = wd;
    #1;
  endtask

  task automatic pick_d(output int unsigned d);
    if (force_d >= 0) begin
      d       = unsigned'(force_d);
      force_d = -1;
    end else if (zero_wait) d = 0;
    else if ($urandom_range(0, 7) == 0) d = $urandom_range(4, 7);
    else d = $urandom_range(0, 2);
  endtask

  task automatic do_reset();
    rstn = 1'b0; mem_ack = 1'b0; start = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    m_pc = '0; m_ir = '0; m_acc = '0; m_halted = 1'b0; m_terr = 1'b0;
    ce_cnt = 0; ill_cnt = 0; busy_cnt = 0; req_cnt = 0;
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 16; k++) begin
      tbmem[k] = '0;
      m_mem[k] = '0;
    end
  endtask

  task automatic put(input int a, input logic [7:0] v);
    tbmem[a] = v;
    m_mem[a] = v;
  endtask

  task automatic start_run();
    rec_t r;
    int unsigned n = $urandom_range(0, 2);
    for (int unsigned i = 0; i < n; i++) begin
      r = base(); r.busy = 1'b0; r.halted = m_halted; r.start = 1'b0;
      cycle(r);
    end
    r = base(); r.busy = 1'b0; r.halted = m_halted; r.start = 1'b1;
    cycle(r);
    m_halted = 1'b0;
  endtask

  // One instruction from the ISA: fetch, one decode cycle, optional operand access.
  task automatic exec_instr();
    rec_t        r;
    int unsigned d;
    logic [7:0]  ins, v;
    logic [3:0]  opc, opd;
    pick_d(d);
    for (int unsigned i = 0; i <= d; i++) begin
      r = base(); r.req = 1'b1; r.addr = m_pc; r.ack = (i == d);
      cycle(r);
    end
    ins  = m_mem[m_pc];
    m_ir = ins;
    m_pc = m_pc + 4'd1;
    opc  = ins[7:4];
    opd  = ins[3:0];
    r = base();
    if (opc == 4'h1) begin r.ce = 1'b1; r.src = 2'd2; end
    if (opc >= 4'hB && opc <= 4'hE) r.ill = 1'b1;
    cycle(r);
    case (opc)
      4'h1: m_acc = {4'h0, opd};
      4'h9: m_pc = opd;
      4'hA: if (m_acc == 8'h00) m_pc = opd;
      4'hF: m_halted = 1'b1;
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
        pick_d(d);
        v = m_mem[opd];
        for (int unsigned i = 0; i <= d; i++) begin
          r = base(); r.req = 1'b1; r.we = (opc == 4'h8); r.addr = opd;
          r.wdata = m_acc; r.ack = (i == d);
          if (i == d && opc != 4'h8) begin
            r.ce  = 1'b1;
            r.src = (opc == 4'h2) ? 2'd1 : 2'd0;
            r.op  = 3'(opc - 4'd3);
          end
          cycle(r);
        end
        case (opc)
          4'h2: m_acc = v;
          4'h3: m_acc = m_acc + v;
          4'h4: m_acc = m_acc - v;
          4'h5: m_acc = m_acc & v;
          4'h6: m_acc = m_acc | v;
          4'h7: m_acc = m_acc ^ v;
          default: m_mem[opd] = m_acc;
        endcase
      end
      default: ;
    endcase
    chk("acc", 32'(acc), 32'(m_acc));
  endtask

  initial begin
    rec_t r;
    rstn = 1'b0; start = 1'b0; mem_ack = 1'b0;
    m_pc = '0; m_ir = '0; m_acc = '0; m_halted = 1'b0; m_terr = 1'b0;
    clear_mem();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_acu_ce", 32'(acu_ce), 0);
    chk("rst_acu_src", 32'(acu_src), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_imm", 32'(imm), 0);

    // Reference program: LDI 5; ADD [E]; ST [F]; HLT with mem[E]=3.
    zero_wait = 1'b1;
    do_reset(); clear_mem();
    put(0, 8'h15); put(1, 8'h3E); put(2, 8'h8F); put(3, 8'hF0); put(14, 8'h03);
    start_run();
    for (int i = 0; i < 4; i++) exec_instr();
    chk("prog_mem_f", 32'(tbmem[15]), 32'h08);
    chk("prog_model_mem_f", 32'(m_mem[15]), 32'h08);
    chk("prog_halted", 32'(halted), 1);
    chk("prog_pc", 32'(pc), 4);
    chk("prog_ce_pulses", 32'(ce_cnt), 2);
    chk("prog_busy_cycles", 32'(busy_cnt), 10);

    // JZ taken with acc=0, then not taken with acc=1.
    do_reset(); clear_mem();
    put(0, 8'h10); put(1, 8'h00); put(2, 8'hA7); put(7, 8'hF0);
    start_run();
    for (int i = 0; i < 3; i++) exec_instr();
    chk("jz_taken_pc", 32'(pc), 7);
    exec_instr();
    do_reset(); clear_mem();
    put(0, 8'h11); put(1, 8'h00); put(2, 8'hA7); put(3, 8'hF0);
    start_run();
    for (int i = 0; i < 3; i++) exec_instr();
    chk("jz_not_taken_pc", 32'(pc), 3);
    exec_instr();

    // Undefined opcode behaves as NOP with a one-cycle illegal pulse.
    do_reset(); clear_mem();
    put(0, 8'hC0); put(1, 8'hF0);
    start_run();
    exec_instr();
    chk("ill_pulses", 32'(ill_cnt), 1);
    chk("ill_no_ce", 32'(ce_cnt), 0);
    chk("ill_one_req", 32'(req_cnt), 1);
    chk("ill_next_pc", 32'(pc), 1);
    exec_instr();

    // Delayed ack on the first fetch, then pc wrap from 15 to 0.
    do_reset(); clear_mem();
    put(0, 8'h9F); put(15, 8'hF0);
    start_run();
    force_d = 3;
    exec_instr();
    chk("delay_req_cycles", 32'(req_cnt), 4);
    chk("jmp_pc", 32'(pc), 15);
    exec_instr();
    chk("wrap_pc", 32'(pc), 0);
    chk("wrap_halted", 32'(halted), 1);

    // Asynchronous reset while ADD waits on its operand.
    do_reset(); clear_mem();
    put(0, 8'h3E); put(14, 8'h05);
    start_run();
    r = base(); r.req = 1'b1; r.addr = 4'h0; r.ack = 1'b1; cycle(r);
    m_ir = 8'h3E; m_pc = 4'h1;
    r = base(); cycle(r);
    r = base(); r.req = 1'b1; r.addr = 4'hE; r.ack = 1'b0; cycle(r);
    mem_ack = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("arst_mem_req", 32'(mem_req), 0);
    chk("arst_acu_ce", 32'(acu_ce), 0);
    chk("arst_pc", 32'(pc), 0);
    chk("arst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    m_pc = '0; m_ir = '0; m_acc = '0; m_halted = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r = base(); r.busy = 1'b0; r.start = 1'b0; cycle(r);
    end

`ifdef SEQ_TIMEOUT_EN
    // No ack for 15 cycles halts with the sticky error; an ack on the 15th cycle wins.
    do_reset(); clear_mem();
    start_run();
    for (int i = 0; i < 15; i++) begin
      r = base(); r.req = 1'b1; r.addr = m_pc; r.ack = 1'b0; cycle(r);
    end
    m_halted = 1'b1; m_terr = 1'b1;
    r = base(); r.busy = 1'b0; r.halted = 1'b1; r.start = 1'b0; cycle(r);
    chk("to_err", 32'(timeout_err), 1);
    chk("to_halted", 32'(halted), 1);
    do_reset(); clear_mem();
    put(1, 8'hF0);
    start_run();
    force_d = 14;
    exec_instr();
    chk("to_late_ack_err", 32'(timeout_err), 0);
    chk("to_late_ack_pc", 32'(pc), 1);
    exec_instr();
`endif

    // Randomized programs with random ack latency, spurious acks and start noise.
    zero_wait = 1'b0;
    for (int p = 0; p < 25; p++) begin
      do_reset();
      for (int k = 0; k < 16; k++) put(k, 8'($urandom));
      start_run();
      for (int n = 0; n < 40; n++) begin
        exec_instr();
        if (m_halted) begin
          if ($urandom_range(0, 1) == 1) start_run();
          else break;
        end
      end
      for (int k = 0; k < 16; k++) chk("rand_mem", 32'(tbmem[k]), 32'(m_mem[k]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
